// File: rtl/huffman_bigvalue_sched.sv
// Big_values Huffman scheduler: splits one granule's pair stream into regions, selects
// each region's table, gates serial bits into the decoder bank and collects decoded pairs.
module huffman_bigvalue_sched #(
    parameter int IDX_W = 10,
    parameter int BV_W  = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BV_W-1:0]         big_values,
    input  logic [IDX_W-1:0]        region1_start,
    input  logic [IDX_W-1:0]        region2_start,
    input  logic [14:0]             table_sel,
    input  logic                    axiiv,
    input  logic                    axiid,
    output logic                    bit_ready,
    output logic [4:0]              ht_sel,
    output logic                    ht_rst,
    output logic                    dec_iv,
    output logic                    dec_id,
    input  logic                    dec_ov,
    input  logic signed [15:0]      dec_x,
    input  logic signed [15:0]      dec_y,
    output logic                    out_valid,
    output logic signed [15:0]      out_x,
    output logic signed [15:0]      out_y,
    output logic [IDX_W-1:0]        out_idx,
    output logic [15:0]             bits_used,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [2:0] {IDLE, SELECT, FEED, ZERO, DONE, ERR} state_t;

    state_t           state;
    logic [IDX_W-1:0] end_idx, r1c, r2c, idx;
    logic [14:0]      tbl;
    logic [5:0]       wd;

    logic [IDX_W-1:0] end_in, nidx;
    logic [1:0]       reg_cur, reg_nxt;
    logic [4:0]       cur_tbl;
    logic             feed_live, accept;

    assign end_in = IDX_W'({big_values, 1'b0});
    assign nidx   = idx + IDX_W'(2);

    always_comb begin
        reg_cur = (idx < r1c) ? 2'd0 : (idx < r2c) ? 2'd1 : 2'd2;
        reg_nxt = (nidx < r1c) ? 2'd0 : (nidx < r2c) ? 2'd1 : 2'd2;
        case (reg_cur)
            2'd0:    cur_tbl = tbl[4:0];
            2'd1:    cur_tbl = tbl[9:5];
            default: cur_tbl = tbl[14:10];
        endcase
    end

    // The cycle carrying ht_rst holds the bank in reset, so no bit is offered then.
    assign feed_live = (state == FEED) && !ht_rst;
    assign bit_ready = feed_live && !dec_ov;
    assign dec_iv    = bit_ready && axiiv;
    assign dec_id    = feed_live && axiid;
    assign accept    = dec_iv;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            end_idx   <= '0;
            r1c       <= '0;
            r2c       <= '0;
            idx       <= '0;
            tbl       <= '0;
            wd        <= '0;
            ht_sel    <= '0;
            ht_rst    <= 1'b0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_idx   <= '0;
            bits_used <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ht_rst    <= 1'b0;
            if (accept && bits_used != 16'hFFFF)
                bits_used <= bits_used + 16'd1;
            case (state)
                IDLE: if (start) begin
                    end_idx   <= end_in;
                    r1c       <= (region1_start > end_in) ? end_in : region1_start;
                    r2c       <= (region2_start > end_in) ? end_in : region2_start;
                    tbl       <= table_sel;
                    idx       <= '0;
                    wd        <= '0;
                    bits_used <= '0;
                    state     <= (big_values == '0) ? DONE : SELECT;
                end
                SELECT: begin
                    ht_sel <= cur_tbl;
                    ht_rst <= 1'b1;
                    wd     <= '0;
                    if (cur_tbl == 5'd4 || cur_tbl == 5'd14) state <= ERR;
                    else if (cur_tbl == 5'd0)                state <= ZERO;
                    else                                     state <= FEED;
                end
                FEED: if (!ht_rst) begin
                    if (dec_ov) begin
                        out_valid <= 1'b1;
                        out_x     <= dec_x;
                        out_y     <= dec_y;
                        out_idx   <= idx;
                        idx       <= nidx;
                        wd        <= '0;
                        if (nidx >= end_idx)         state <= DONE;
                        else if (reg_nxt != reg_cur) state <= SELECT;
                    end else if (accept) begin
                        wd <= wd + 6'd1;
                        if (wd == 6'd40) state <= ERR;
                    end
                end
                ZERO: begin
                    out_valid <= 1'b1;
                    out_x     <= '0;
                    out_y     <= '0;
                    out_idx   <= idx;
                    idx       <= nidx;
                    if (nidx >= end_idx)         state <= DONE;
                    else if (reg_nxt != reg_cur) state <= SELECT;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                ERR: begin
                    err   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_bigvalue_sched.sv
// Directed bench for huffman_bigvalue_sched with a scripted decoder-bank model
// that completes a pair after a fixed number of forwarded bits.
module tb_huffman_bigvalue_sched;
    localparam int IDX_W = 10;
    localparam int BV_W  = 9;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [BV_W-1:0]  big_values = '0;
    logic [IDX_W-1:0] region1_start = '0, region2_start = '0;
    logic [14:0]      table_sel = '0;
    logic axiiv = 1'b0, axiid = 1'b0;
    logic bit_ready, ht_rst, dec_iv, dec_id, dec_ov, out_valid, busy, done, err;
    logic [4:0] ht_sel;
    logic signed [15:0] dec_x, dec_y, out_x, out_y;
    logic [IDX_W-1:0] out_idx;
    logic [15:0] bits_used;

    int checks = 0;
    int failures = 0;

    huffman_bigvalue_sched #(.IDX_W(IDX_W), .BV_W(BV_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .big_values(big_values),
        .region1_start(region1_start), .region2_start(region2_start), .table_sel(table_sel),
        .axiiv(axiiv), .axiid(axiid), .bit_ready(bit_ready), .ht_sel(ht_sel), .ht_rst(ht_rst),
        .dec_iv(dec_iv), .dec_id(dec_id), .dec_ov(dec_ov), .dec_x(dec_x), .dec_y(dec_y),
        .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_idx(out_idx),
        .bits_used(bits_used), .busy(busy), .done(done), .err(err));

    always #5 clk = ~clk;

    // Decoder-bank model: pair k completes after need_a[k] forwarded bits
    int need_a [4];
    logic signed [15:0] xa [4];
    logic signed [15:0] ya [4];
    int npairs = 0;
    int mptr = 0;
    int mcnt = 0;
    int idmis = 0;
    logic [63:0] bseq = '0;
    logic [5:0] bptr = '0;
    bit rnd_mode = 1'b0;

    always_comb begin
        dec_ov = 1'b0;
        dec_x  = '0;
        dec_y  = '0;
        if (mptr < npairs && mcnt == need_a[mptr]) begin
            dec_ov = 1'b1;
            dec_x  = xa[mptr];
            dec_y  = ya[mptr];
        end
    end

    always @(posedge clk) begin
        if (start && !busy) begin
            mptr <= 0;
            mcnt <= 0;
            bptr <= '0;
        end else begin
            if (ht_rst) mcnt <= 0;
            else if (dec_ov) begin
                mcnt <= 0;
                mptr <= mptr + 1;
            end else if (dec_iv) mcnt <= mcnt + 1;
            if (axiiv && bit_ready) bptr <= bptr + 6'd1;
            if (dec_iv && dec_id !== bseq[bptr]) idmis <= idmis + 1;
        end
    end

    always @(negedge clk) begin
        axiiv = !rnd_mode || ($urandom_range(0, 1) == 1);
        axiid = bseq[bptr];
    end

    // Monitor: every pair strobe, with bits_used at that moment
    logic signed [15:0] px [32];
    logic signed [15:0] py [32];
    logic [IDX_W-1:0] pidx [32];
    logic [15:0] pbits [32];
    int np = 0;
    int n_done = 0;
    int n_err = 0;
    int seen_sel1 = 0;

    always @(negedge clk) begin
        if (out_valid && np < 32) begin
            px[np] = out_x; py[np] = out_y; pidx[np] = out_idx; pbits[np] = bits_used;
            np++;
        end
        if (done) n_done++;
        if (err) n_err++;
        if (ht_rst && ht_sel == 5'd1) seen_sel1++;
    end

    task automatic run(input logic [BV_W-1:0] bv, input logic [IDX_W-1:0] r1, r2,
                       input logic [14:0] ts, input bit rnd, input int budget,
                       input int restart_at, output int cyc);
        big_values = bv; region1_start = r1; region2_start = r2; table_sel = ts;
        rnd_mode = rnd;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == restart_at);
            if (cyc == restart_at) big_values = '0;
            #1;
            if (done || err) break;
        end
        start = 1'b0;
        if (cyc >= budget) begin
            checks++; failures++;
            $display("FAIL run_timeout: cycles=%0d required_below=%0d", cyc, budget);
        end
        @(negedge clk);
    endtask

    task automatic script_test2();
        need_a[0] = 2; xa[0] = 16'sd0; ya[0] = 16'sd0;
        need_a[1] = 5; xa[1] = 16'sd1; ya[1] = -16'sd1;
        npairs = 2;
        bseq = 64'b1101011;
        bseq = {57'd0, 7'b1101011};
        // bit order on the wire: 1 1 0 1 0 1 1 -> bseq[0]=1, [1]=1, [2]=0, [3]=1, [4]=0, [5]=1, [6]=1
        bseq[6:0] = 7'b1101011;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, bit_ready, dec_iv, ht_rst, out_valid, done, err, ht_sel, bits_used} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b out_valid=%b ht_sel=%0d bits_used=%0d required all 0",
                     busy, out_valid, ht_sel, bits_used);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_zero_pairs();
        int cyc, p0;
        npairs = 0; p0 = np;
        run(9'd0, 10'd576, 10'd576, 15'h0421, 1'b0, 20, 0, cyc);
        checks++;
        if (cyc != 2 || n_done != 1) begin
            failures++;
            $display("FAIL zero_bv_done: cycles=%0d dones=%0d required 2 1", cyc, n_done);
        end
        checks++;
        if (np != p0 || bits_used !== 16'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_bv_state: pairs=%0d bits=%0d busy=%b required 0 0 0",
                     np - p0, bits_used, busy);
        end
    endtask

    task automatic test_feed();
        int cyc, p0, e0;
        script_test2();
        p0 = np; e0 = n_done;
        run(9'd2, 10'd576, 10'd576, 15'h0001, 1'b0, 60, 0, cyc);
        checks++;
        if (np - p0 != 2 || n_done != e0 + 1 || cyc != 13) begin
            failures++;
            $display("FAIL feed_count: pairs=%0d dones=%0d cycles=%0d required 2 1 13",
                     np - p0, n_done - e0, cyc);
        end else begin
            checks++;
            if (px[p0] !== 16'sd0 || py[p0] !== 16'sd0 || pidx[p0] !== 10'd0) begin
                failures++;
                $display("FAIL feed_pair0: got (%0d,%0d)@%0d required (0,0)@0", px[p0], py[p0], pidx[p0]);
            end
            checks++;
            if (px[p0+1] !== 16'sd1 || py[p0+1] !== -16'sd1 || pidx[p0+1] !== 10'd2) begin
                failures++;
                $display("FAIL feed_pair1: got (%0d,%0d)@%0d required (1,-1)@2",
                         px[p0+1], py[p0+1], pidx[p0+1]);
            end
        end
        checks++;
        if (bits_used !== 16'd7 || idmis != 0) begin
            failures++;
            $display("FAIL feed_bits: bits_used=%0d id_mismatches=%0d required 7 0", bits_used, idmis);
        end
    endtask

    task automatic test_zero_region();
        int cyc, p0, s0;
        need_a[0] = 3; xa[0] = 16'sd2; ya[0] = 16'sd3; npairs = 1;
        bseq[2:0] = 3'b101;
        p0 = np; s0 = seen_sel1;
        run(9'd3, 10'd4, 10'd576, {5'd0, 5'd1, 5'd0}, 1'b0, 60, 0, cyc);
        checks++;
        if (np - p0 != 3 || cyc != 11) begin
            failures++;
            $display("FAIL zero_region_count: pairs=%0d cycles=%0d required 3 11", np - p0, cyc);
        end else begin
            checks++;
            if (px[p0] !== 0 || py[p0] !== 0 || pidx[p0] !== 10'd0 ||
                px[p0+1] !== 0 || py[p0+1] !== 0 || pidx[p0+1] !== 10'd2 || pbits[p0+1] !== 16'd0) begin
                failures++;
                $display("FAIL zero_region_pairs: idx %0d,%0d bits %0d required idx 0,2 bits 0",
                         pidx[p0], pidx[p0+1], pbits[p0+1]);
            end
            checks++;
            if (px[p0+2] !== 16'sd2 || py[p0+2] !== 16'sd3 || pidx[p0+2] !== 10'd4) begin
                failures++;
                $display("FAIL zero_region_feed: got (%0d,%0d)@%0d required (2,3)@4",
                         px[p0+2], py[p0+2], pidx[p0+2]);
            end
        end
        checks++;
        if (seen_sel1 - s0 != 1 || bits_used !== 16'd3) begin
            failures++;
            $display("FAIL zero_region_select: ht_rst_with_sel1=%0d bits=%0d required 1 3",
                     seen_sel1 - s0, bits_used);
        end
    endtask

    task automatic test_bad_table();
        int cyc, p0, d0, e0;
        need_a[0] = 2; xa[0] = 16'sd1; ya[0] = 16'sd1; npairs = 2;
        need_a[1] = 2; xa[1] = 16'sd5; ya[1] = 16'sd5;
        p0 = np; d0 = n_done; e0 = n_err;
        run(9'd2, 10'd2, 10'd576, {5'd0, 5'd4, 5'd1}, 1'b0, 60, 0, cyc);
        checks++;
        if (n_err != e0 + 1 || n_done != d0 || cyc != 8) begin
            failures++;
            $display("FAIL bad_table_err: errs=%0d dones=%0d cycles=%0d required 1 0 8",
                     n_err - e0, n_done - d0, cyc);
        end
        checks++;
        if (np - p0 != 1 || ht_sel !== 5'd4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_table_state: pairs=%0d ht_sel=%0d busy=%b required 1 4 0",
                     np - p0, ht_sel, busy);
        end
    endtask

    task automatic test_watchdog();
        int cyc, e0;
        need_a[0] = 60; xa[0] = 0; ya[0] = 0; npairs = 1;
        e0 = n_err;
        run(9'd1, 10'd576, 10'd576, 15'h0001, 1'b0, 100, 0, cyc);
        checks++;
        if (n_err != e0 + 1 || bits_used !== 16'd41 || cyc != 45) begin
            failures++;
            $display("FAIL watchdog: errs=%0d bits=%0d cycles=%0d required 1 41 45",
                     n_err - e0, bits_used, cyc);
        end
    endtask

    task automatic test_random_stall();
        int cyc, p0;
        script_test2();
        p0 = np;
        run(9'd2, 10'd576, 10'd576, 15'h0001, 1'b1, 400, 6, cyc);
        rnd_mode = 1'b0;
        checks++;
        if (np - p0 != 2 || bits_used !== 16'd7) begin
            failures++;
            $display("FAIL stall_count: pairs=%0d bits=%0d required 2 7", np - p0, bits_used);
        end else begin
            checks++;
            if (px[p0] !== 0 || py[p0] !== 0 || pidx[p0] !== 10'd0 ||
                px[p0+1] !== 16'sd1 || py[p0+1] !== -16'sd1 || pidx[p0+1] !== 10'd2) begin
                failures++;
                $display("FAIL stall_pairs: got (%0d,%0d)@%0d (%0d,%0d)@%0d required (0,0)@0 (1,-1)@2",
                         px[p0], py[p0], pidx[p0], px[p0+1], py[p0+1], pidx[p0+1]);
            end
        end
    endtask

    task automatic test_reset_mid_feed();
        int cyc, p0, d0;
        script_test2();
        big_values = 9'd2; region1_start = 10'd576; region2_start = 10'd576; table_sel = 15'h0001;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bits_used !== 16'd1) begin
            failures++;
            $display("FAIL midfeed_pre: busy=%b bits=%0d required 1 1", busy, bits_used);
        end
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, bit_ready, dec_iv, dec_id, ht_rst, out_valid, done, err, ht_sel,
             out_x, out_y, out_idx, bits_used} !== '0) begin
            failures++;
            $display("FAIL midfeed_reset: busy=%b ready=%b ht_sel=%0d bits=%0d required all 0",
                     busy, bit_ready, ht_sel, bits_used);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = np;
        run(9'd2, 10'd576, 10'd576, 15'h0001, 1'b0, 60, 0, cyc);
        checks++;
        if (np - p0 != 2 || n_done != d0 + 1 || cyc != 13 || pidx[p0+1] !== 10'd2 || px[p0+1] !== 16'sd1) begin
            failures++;
            $display("FAIL midfeed_rerun: pairs=%0d dones=%0d cycles=%0d required 2 1 13",
                     np - p0, n_done - d0, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_zero_pairs();
        test_feed();
        test_zero_region();
        test_bad_table();
        test_watchdog();
        test_random_stall();
        test_reset_mid_feed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
